soc1_nios_jtag_cmd_bridge: RTL and testbench
============================================

SOC1_NIOS_JTAG_CMD_BRIDGE -- requirements
Module: soc1_nios_jtag_cmd_bridge

Interface
REQ-001 Parameter IR_WIDTH, default 2, JTAG instruction width; legal range 1..4.
REQ-002 Parameter DR_WIDTH, default 38, captured data-register width; legal range 2..64.
REQ-003 Parameter SYNC_STAGES, default 2, synchronizer depth for TCK-domain strobes; legal range 2..4.
REQ-004 clk  in  1  sole clock; every flop in the block is clocked on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 vs_udr  in  1  update-DR strobe, asynchronous to clk.
REQ-007 vs_uir  in  1  update-IR strobe, asynchronous to clk.
REQ-008 ir_in  in  IR_WIDTH  current instruction; quasi-static, stable ≥SYNC_STAGES+2 clk around each strobe.
REQ-009 sr  in  DR_WIDTH  shift-register contents; same stability rule as ir_in.
REQ-010 cmd_valid  out  1  held command available.
REQ-011 cmd_ready  in  1  consumer accepts held command.
REQ-012 cmd_kind  out  1  0 = UDR event, 1 = UIR event.
REQ-013 cmd_ir  out  IR_WIDTH  instruction captured with the command.
REQ-014 cmd_data  out  DR_WIDTH  sr captured with the command (jdo equivalent).
REQ-015 take_action  out  2**IR_WIDTH  one-hot single-cycle action pulses, indexed by instruction.
REQ-016 take_no_action  out  2**IR_WIDTH  one-hot single-cycle no-action pulses, indexed by instruction.
REQ-017 overrun  out  1  sticky: an event was dropped.
REQ-018 overrun_clr  in  1  clears overrun.
REQ-019 cmd_count  out  8  count of loaded events, modulo 256.

Function
REQ-020 Each strobe SHALL pass through SYNC_STAGES flops plus one history flop; a 0→1 transition yields a one-cycle internal event (udr_ev / uir_ev).
REQ-021 Latency: strobe rise to cmd_valid high SHALL be SYNC_STAGES+1 clk (±1 for metastability resolution).
REQ-022 Holding register has states EMPTY and FULL; cmd_valid = (state == FULL).
REQ-023 EMPTY with an event: load cmd_kind/cmd_ir/cmd_data from the event, go to FULL.
REQ-024 FULL with cmd_ready and no event: go to EMPTY; held outputs may retain stale values.
REQ-025 FULL with cmd_ready and an event in the same cycle: load new event, stay FULL, no bubble.
REQ-026 FULL, no cmd_ready, event present: drop the event, keep held data unchanged, set overrun.
REQ-027 udr_ev and uir_ev in the same cycle: UDR is loaded (subject to REQ-026); UIR is dropped and sets overrun.
REQ-028 On each loaded UDR event with ir_in = k: take_action[k] pulses if sr[DR_WIDTH-1]=1, else take_no_action[k] pulses; the pulse is coincident with the first cycle of cmd_valid for that command.
REQ-029 UIR events and dropped events SHALL produce no take_action/take_no_action pulse; at most one bit across both vectors is high in any cycle.
REQ-030 cmd_count increments by 1 per loaded event; 255 wraps to 0; dropped events do not count.
REQ-031 overrun stays high until overrun_clr; a set and overrun_clr in the same cycle leaves overrun = 1.

Reset
REQ-032 While reset is high: state EMPTY; cmd_valid, cmd_kind, cmd_ir, cmd_data, take_action, take_no_action, overrun, cmd_count = 0; synchronizer and history flops = 0.
REQ-033 For SYNC_STAGES+1 cycles after reset deasserts, edge detection SHALL be suppressed (history tracks input), so a strobe already high at release generates no event.
REQ-034 Reset asserted mid-handshake SHALL discard the held command without a pulse or overrun; reset has priority over every other input.

Verification
REQ-035 Defaults, ir_in=2, sr[37]=1, sr=0x2A_1234_5678, pulse vs_udr -> after 3 clk: cmd_valid=1, cmd_kind=0, cmd_ir=2, cmd_data=sr, take_action=4'b0100 for exactly 1 clk, cmd_count=1.
REQ-036 Hold cmd_ready=0, send two UDR strobes -> first held unchanged, overrun=1, cmd_count=1; pulse overrun_clr -> overrun=0.
REQ-037 cmd_ready=1 in the same cycle as a second udr_ev -> cmd_valid stays high, second data loaded, cmd_count=2, overrun=0.
REQ-038 vs_udr and vs_uir rising together, ir_in=1, sr[37]=0 -> UDR loaded, take_no_action=4'b0010, overrun=1.
REQ-039 vs_udr held high through reset release -> no event, cmd_valid=0; falling then rising afterwards -> exactly one event.
REQ-040 256 accepted UIR events -> cmd_count=0, no take pulses; reset asserted while FULL -> all outputs 0 next clk.

Source files
------------

// File: rtl/soc1_nios_jtag_cmd_bridge.sv
// soc1_nios_jtag_cmd_bridge
// Brings JTAG update-DR / update-IR strobes from the TCK domain into clk,
// turns their rising edges into single-cycle events, and presents each event
// as a held command (kind, instruction, shift data) with a valid/ready
// handshake. Loaded UDR commands also produce one-hot action pulses indexed
// by the instruction. Events that find the holding register busy are dropped
// and flagged on the sticky overrun output.
module soc1_nios_jtag_cmd_bridge #(
    parameter int IR_WIDTH    = 2,
    parameter int DR_WIDTH    = 38,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       vs_udr,
    input  logic                       vs_uir,
    input  logic [IR_WIDTH-1:0]        ir_in,
    input  logic [DR_WIDTH-1:0]        sr,
    output logic                       cmd_valid,
    input  logic                       cmd_ready,
    output logic                       cmd_kind,
    output logic [IR_WIDTH-1:0]        cmd_ir,
    output logic [DR_WIDTH-1:0]        cmd_data,
    output logic [(1<<IR_WIDTH)-1:0]   take_action,
    output logic [(1<<IR_WIDTH)-1:0]   take_no_action,
    output logic                       overrun,
    input  logic                       overrun_clr,
    output logic [7:0]                 cmd_count
);

    localparam int NUM_INSTR = 1 << IR_WIDTH;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    // Edge detection stays blind for this many cycles after reset release so
    // that a strobe already high at release is absorbed into the history flop.
    localparam logic [2:0] SUPPRESS_CYCLES = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] udr_sync;
    logic [SYNC_STAGES-1:0] uir_sync;
    logic                   udr_hist;
    logic                   uir_hist;
    logic [2:0]             suppress_cnt;
    logic                   edge_ok;
    logic                   udr_ev;
    logic                   uir_ev;
    logic [0:0]             state;

    logic                   any_ev;
    logic                   can_load;
    logic                   do_load;
    logic                   drop;
    logic                   pulse_ev;
    logic [NUM_INSTR-1:0]   instr_hot;

    // Synchronizer chains plus one history flop per strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            udr_sync <= '0;
            uir_sync <= '0;
            udr_hist <= 1'b0;
            uir_hist <= 1'b0;
        end else begin
            udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
            uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
            udr_hist <= udr_sync[SYNC_STAGES-1];
            uir_hist <= uir_sync[SYNC_STAGES-1];
        end
    end

    // Post-reset window during which edges are ignored
    always_ff @(posedge clk) begin
        if (reset) begin
            suppress_cnt <= SUPPRESS_CYCLES;
        end else if (suppress_cnt != 3'd0) begin
            suppress_cnt <= suppress_cnt - 3'd1;
        end
    end

    assign edge_ok   = (suppress_cnt == 3'd0);
    assign udr_ev    = udr_sync[SYNC_STAGES-1] & ~udr_hist & edge_ok;
    assign uir_ev    = uir_sync[SYNC_STAGES-1] & ~uir_hist & edge_ok;
    assign cmd_valid = (state == ST_FULL);

    // Load / drop decision and instruction decode for the action pulses
    always_comb begin
        any_ev   = udr_ev | uir_ev;
        can_load = (state == ST_EMPTY) | cmd_ready;
        do_load  = any_ev & can_load;
        // A simultaneous UIR always loses to UDR, even when UDR itself loads.
        drop     = (any_ev & ~can_load) | (udr_ev & uir_ev);
        pulse_ev = do_load & udr_ev;
        instr_hot = '0;
        for (int i = 0; i < NUM_INSTR; i++) begin
            instr_hot[i] = (ir_in == IR_WIDTH'(i));
        end
    end

    // Holding register: EMPTY/FULL state and the captured command fields
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_EMPTY;
            cmd_kind <= 1'b0;
            cmd_ir   <= '0;
            cmd_data <= '0;
        end else if (do_load) begin
            state    <= ST_FULL;
            cmd_kind <= ~udr_ev;
            cmd_ir   <= ir_in;
            cmd_data <= sr;
        end else if ((state == ST_FULL) && cmd_ready) begin
            state    <= ST_EMPTY;
        end
    end

    // Action pulses land in the same cycle the command first shows valid
    always_ff @(posedge clk) begin
        if (reset) begin
            take_action    <= '0;
            take_no_action <= '0;
        end else begin
            take_action    <= (pulse_ev &  sr[DR_WIDTH-1]) ? instr_hot : '0;
            take_no_action <= (pulse_ev & ~sr[DR_WIDTH-1]) ? instr_hot : '0;
        end
    end

    // Sticky overrun flag; a new drop wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

    // Count of loaded events, wrapping at 256
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_count <= 8'd0;
        end else if (do_load) begin
            cmd_count <= cmd_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_soc1_nios_jtag_cmd_bridge.sv
// Bench for soc1_nios_jtag_cmd_bridge: directed scenarios plus a randomized
// run compared against an event-level reference model.
module tb_soc1_nios_jtag_cmd_bridge;

    localparam int IRW = 2;
    localparam int DRW = 38;
    localparam int S   = 2;
    localparam int NA  = 4;
    localparam logic [DRW-1:0] SR_A = 38'h2A_1234_5678;

    logic           clk = 1'b0;
    logic           reset;
    logic           vs_udr;
    logic           vs_uir;
    logic [IRW-1:0] ir_in;
    logic [DRW-1:0] sr;
    logic           cmd_valid;
    logic           cmd_ready;
    logic           cmd_kind;
    logic [IRW-1:0] cmd_ir;
    logic [DRW-1:0] cmd_data;
    logic [NA-1:0]  take_action;
    logic [NA-1:0]  take_no_action;
    logic           overrun;
    logic           overrun_clr;
    logic [7:0]     cmd_count;

    int total = 0;
    int bad   = 0;

    // Reference model: strobe rises become events S edges later, unless
    // they land inside the S+1 edge window following reset release.
    int             cyc = 0;
    int             rst_last = 0;
    bit             udr_ring [16];
    bit             uir_ring [16];
    bit             prev_udr = 1'b0;
    bit             prev_uir = 1'b0;
    bit             m_full = 1'b0;
    bit             m_kind = 1'b0;
    logic [IRW-1:0] m_ir = '0;
    logic [DRW-1:0] m_data = '0;
    logic [NA-1:0]  m_ta = '0;
    logic [NA-1:0]  m_tna = '0;
    bit             m_ovr = 1'b0;
    logic [7:0]     m_cnt = '0;

    always #5 clk = ~clk;

    soc1_nios_jtag_cmd_bridge #(
        .IR_WIDTH(IRW), .DR_WIDTH(DRW), .SYNC_STAGES(S)
    ) dut (
        .clk(clk), .reset(reset), .vs_udr(vs_udr), .vs_uir(vs_uir),
        .ir_in(ir_in), .sr(sr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_kind(cmd_kind), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
        .take_action(take_action), .take_no_action(take_no_action),
        .overrun(overrun), .overrun_clr(overrun_clr), .cmd_count(cmd_count)
    );

    // One clock: advance the model with the inputs the DUT sees at this edge,
    // then return on the falling edge where outputs are sampled.
    task automatic step();
        bit u;
        bit i;
        bit room;
        @(posedge clk);
        cyc++;
        u = udr_ring[cyc % 16];
        i = uir_ring[cyc % 16];
        udr_ring[cyc % 16] = 1'b0;
        uir_ring[cyc % 16] = 1'b0;
        if (reset || (cyc - rst_last) <= S + 1) begin
            u = 1'b0;
            i = 1'b0;
        end
        if (vs_udr && !prev_udr) udr_ring[(cyc + S) % 16] = 1'b1;
        if (vs_uir && !prev_uir) uir_ring[(cyc + S) % 16] = 1'b1;
        prev_udr = vs_udr;
        prev_uir = vs_uir;
        m_ta  = '0;
        m_tna = '0;
        if (reset) begin
            rst_last = cyc;
            m_full = 1'b0; m_kind = 1'b0; m_ir = '0; m_data = '0;
            m_ovr = 1'b0; m_cnt = '0;
        end else begin
            room = !m_full || cmd_ready;
            if ((u || i) && room) begin
                m_full = 1'b1;
                m_kind = !u;
                m_ir   = ir_in;
                m_data = sr;
                m_cnt  = m_cnt + 8'd1;
                if (u) begin
                    if (sr[DRW-1]) m_ta[ir_in] = 1'b1;
                    else           m_tna[ir_in] = 1'b1;
                end
            end else if (m_full && cmd_ready) begin
                m_full = 1'b0;
            end
            if (((u || i) && !room) || (u && i)) m_ovr = 1'b1;
            else if (overrun_clr)                m_ovr = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        vs_udr = 1'b0; vs_uir = 1'b0; cmd_ready = 1'b0;
        overrun_clr = 1'b0; ir_in = '0; sr = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        repeat (S + 2) step();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        step(); step();
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h want=0", cmd_valid); end
        total++; if (cmd_kind !== 1'b0) begin bad++; $display("FAIL reset_kind got=%0h want=0", cmd_kind); end
        total++; if (cmd_ir !== '0) begin bad++; $display("FAIL reset_ir got=%0h want=0", cmd_ir); end
        total++; if (cmd_data !== '0) begin bad++; $display("FAIL reset_data got=%0h want=0", cmd_data); end
        total++; if (take_action !== '0) begin bad++; $display("FAIL reset_ta got=%0h want=0", take_action); end
        total++; if (take_no_action !== '0) begin bad++; $display("FAIL reset_tna got=%0h want=0", take_no_action); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_ovr got=%0h want=0", overrun); end
        total++; if (cmd_count !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0h want=0", cmd_count); end
        reset = 1'b0;
        repeat (S + 2) step();
    endtask

    task automatic test_basic_udr();
        idle_inputs();
        do_reset();
        ir_in = 2'd2; sr = SR_A;
        vs_udr = 1'b1; step(); vs_udr = 1'b0;
        step();
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL basic_early got=%0h want=0", cmd_valid); end
        step();
        total++; if (cmd_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0h want=1", cmd_valid); end
        total++; if (cmd_kind !== 1'b0) begin bad++; $display("FAIL basic_kind got=%0h want=0", cmd_kind); end
        total++; if (cmd_ir !== 2'd2) begin bad++; $display("FAIL basic_ir got=%0h want=2", cmd_ir); end
        total++; if (cmd_data !== SR_A) begin bad++; $display("FAIL basic_data got=%0h want=%0h", cmd_data, SR_A); end
        total++; if (take_action !== 4'b0100) begin bad++; $display("FAIL basic_ta got=%0h want=4", take_action); end
        total++; if (take_no_action !== 4'b0000) begin bad++; $display("FAIL basic_tna got=%0h want=0", take_no_action); end
        total++; if (cmd_count !== 8'd1) begin bad++; $display("FAIL basic_cnt got=%0h want=1", cmd_count); end
        step();
        total++; if (take_action !== 4'b0000) begin bad++; $display("FAIL basic_ta_once got=%0h want=0", take_action); end
        total++; if (cmd_valid !== 1'b1) begin bad++; $display("FAIL basic_hold got=%0h want=1", cmd_valid); end
        cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL basic_accept got=%0h want=0", cmd_valid); end
    endtask

    task automatic test_overrun();
        logic [DRW-1:0] sa;
        logic [DRW-1:0] sb;
        logic [63:0]    r;
        idle_inputs();
        do_reset();
        r = {$urandom, $urandom}; sa = r[DRW-1:0];
        r = {$urandom, $urandom}; sb = r[DRW-1:0] ^ 38'h1;
        ir_in = 2'd0; sr = sa;
        vs_udr = 1'b1; step(); vs_udr = 1'b0;
        repeat (4) step();
        sr = sb; ir_in = 2'd3;
        vs_udr = 1'b1; step(); vs_udr = 1'b0;
        repeat (4) step();
        total++; if (cmd_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%0h want=1", cmd_valid); end
        total++; if (cmd_data !== sa) begin bad++; $display("FAIL ovr_data got=%0h want=%0h", cmd_data, sa); end
        total++; if (cmd_ir !== 2'd0) begin bad++; $display("FAIL ovr_ir got=%0h want=0", cmd_ir); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%0h want=1", overrun); end
        total++; if (cmd_count !== 8'd1) begin bad++; $display("FAIL ovr_cnt got=%0h want=1", cmd_count); end
        overrun_clr = 1'b1; step(); overrun_clr = 1'b0;
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clr got=%0h want=0", overrun); end
        // Drop lands on the same edge as a clear: the flag must stay set.
        vs_udr = 1'b1; step(); vs_udr = 1'b0;
        repeat (S - 1) step();
        overrun_clr = 1'b1; step(); overrun_clr = 1'b0;
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set_wins got=%0h want=1", overrun); end
        total++; if (cmd_count !== 8'd1) begin bad++; $display("FAIL ovr_cnt2 got=%0h want=1", cmd_count); end
        overrun_clr = 1'b1; step(); overrun_clr = 1'b0;
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clr2 got=%0h want=0", overrun); end
    endtask

    task automatic test_back_to_back();
        logic [DRW-1:0] sb;
        idle_inputs();
        do_reset();
        ir_in = 2'd3; sr = 38'h0_0000_1111;
        vs_udr = 1'b1; step(); vs_udr = 1'b0;
        repeat (4) step();
        total++; if (take_no_action !== 4'b0000) begin bad++; $display("FAIL b2b_tna_first got=%0h want=0", take_no_action); end
        sb = 38'h3F_FFFF_0002;
        ir_in = 2'd1; sr = sb;
        vs_udr = 1'b1; step(); vs_udr = 1'b0;
        repeat (S - 1) step();
        cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
        total++; if (cmd_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%0h want=1", cmd_valid); end
        total++; if (cmd_data !== sb) begin bad++; $display("FAIL b2b_data got=%0h want=%0h", cmd_data, sb); end
        total++; if (cmd_ir !== 2'd1) begin bad++; $display("FAIL b2b_ir got=%0h want=1", cmd_ir); end
        total++; if (cmd_count !== 8'd2) begin bad++; $display("FAIL b2b_cnt got=%0h want=2", cmd_count); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_ovr got=%0h want=0", overrun); end
        total++; if (take_action !== 4'b0010) begin bad++; $display("FAIL b2b_ta got=%0h want=2", take_action); end
    endtask

    task automatic test_dual_strobe();
        idle_inputs();
        do_reset();
        ir_in = 2'd1; sr = 38'h1F_0F0F_0F0F;
        vs_udr = 1'b1; vs_uir = 1'b1; step(); vs_udr = 1'b0; vs_uir = 1'b0;
        repeat (S) step();
        total++; if (cmd_valid !== 1'b1) begin bad++; $display("FAIL dual_valid got=%0h want=1", cmd_valid); end
        total++; if (cmd_kind !== 1'b0) begin bad++; $display("FAIL dual_kind got=%0h want=0", cmd_kind); end
        total++; if (take_no_action !== 4'b0010) begin bad++; $display("FAIL dual_tna got=%0h want=2", take_no_action); end
        total++; if (take_action !== 4'b0000) begin bad++; $display("FAIL dual_ta got=%0h want=0", take_action); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL dual_ovr got=%0h want=1", overrun); end
        total++; if (cmd_count !== 8'd1) begin bad++; $display("FAIL dual_cnt got=%0h want=1", cmd_count); end
    endtask

    task automatic test_reset_release();
        idle_inputs();
        vs_udr = 1'b1;
        reset = 1'b1; step(); step(); reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL rel_valid cyc%0d got=%0h want=0", k, cmd_valid); end
        end
        total++; if (cmd_count !== 8'd0) begin bad++; $display("FAIL rel_cnt0 got=%0h want=0", cmd_count); end
        vs_udr = 1'b0; step();
        vs_udr = 1'b1; step();
        repeat (S) step();
        total++; if (cmd_valid !== 1'b1) begin bad++; $display("FAIL rel_event got=%0h want=1", cmd_valid); end
        repeat (6) step();
        total++; if (cmd_count !== 8'd1) begin bad++; $display("FAIL rel_cnt1 got=%0h want=1", cmd_count); end
        vs_udr = 1'b0; step();
    endtask

    task automatic test_wrap_and_reset_full();
        idle_inputs();
        do_reset();
        cmd_ready = 1'b1;
        for (int n = 0; n < 256; n++) begin
            vs_uir = 1'b1; step();
            total++; if ((take_action | take_no_action) !== 4'b0000) begin bad++; $display("FAIL wrap_pulse n%0d got=%0h want=0", n, take_action | take_no_action); end
            vs_uir = 1'b0; step();
        end
        repeat (S + 1) step();
        total++; if (cmd_count !== 8'd0) begin bad++; $display("FAIL wrap_cnt got=%0h want=0", cmd_count); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL wrap_ovr got=%0h want=0", overrun); end
        cmd_ready = 1'b0;
        ir_in = 2'd3; sr = 38'h15_5555_5555;
        vs_uir = 1'b1; step(); vs_uir = 1'b0;
        repeat (S + 1) step();
        vs_uir = 1'b1; step(); vs_uir = 1'b0;
        repeat (S + 1) step();
        total++; if (cmd_valid !== 1'b1 || overrun !== 1'b1) begin bad++; $display("FAIL full_pre got=%0h%0h want=11", cmd_valid, overrun); end
        reset = 1'b1; step();
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL rf_valid got=%0h want=0", cmd_valid); end
        total++; if (cmd_kind !== 1'b0) begin bad++; $display("FAIL rf_kind got=%0h want=0", cmd_kind); end
        total++; if (cmd_ir !== '0) begin bad++; $display("FAIL rf_ir got=%0h want=0", cmd_ir); end
        total++; if (cmd_data !== '0) begin bad++; $display("FAIL rf_data got=%0h want=0", cmd_data); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rf_ovr got=%0h want=0", overrun); end
        total++; if (cmd_count !== 8'd0) begin bad++; $display("FAIL rf_cnt got=%0h want=0", cmd_count); end
        total++; if ((take_action | take_no_action) !== '0) begin bad++; $display("FAIL rf_pulse got=%0h want=0", take_action | take_no_action); end
        reset = 1'b0;
        repeat (S + 2) step();
    endtask

    task automatic test_random();
        logic [63:0] r;
        int          pat;
        int          hold;
        idle_inputs();
        do_reset();
        for (int e = 0; e < 150; e++) begin
            r = {$urandom, $urandom};
            sr    = r[DRW-1:0];
            ir_in = IRW'($urandom_range(0, NA - 1));
            pat   = $urandom_range(0, 3);
            hold  = $urandom_range(1, 2);
            for (int c = 0; c < hold + S + 3; c++) begin
                vs_udr      = (c < hold) && pat[0];
                vs_uir      = (c < hold) && pat[1];
                cmd_ready   = ($urandom_range(0, 2) == 0);
                overrun_clr = ($urandom_range(0, 7) == 0);
                reset       = (c == hold + 1) && ($urandom_range(0, 24) == 0);
                step();
                total++; if (cmd_valid !== m_full) begin bad++; $display("FAIL rnd_valid e%0d got=%0h want=%0h", e, cmd_valid, m_full); end
                total++; if (take_action !== m_ta) begin bad++; $display("FAIL rnd_ta e%0d got=%0h want=%0h", e, take_action, m_ta); end
                total++; if (take_no_action !== m_tna) begin bad++; $display("FAIL rnd_tna e%0d got=%0h want=%0h", e, take_no_action, m_tna); end
                total++; if (overrun !== m_ovr) begin bad++; $display("FAIL rnd_ovr e%0d got=%0h want=%0h", e, overrun, m_ovr); end
                total++; if (cmd_count !== m_cnt) begin bad++; $display("FAIL rnd_cnt e%0d got=%0h want=%0h", e, cmd_count, m_cnt); end
                if (m_full) begin
                    total++; if ({cmd_kind, cmd_ir, cmd_data} !== {m_kind, m_ir, m_data}) begin
                        bad++; $display("FAIL rnd_cmd e%0d got=%0h/%0h/%0h want=%0h/%0h/%0h", e, cmd_kind, cmd_ir, cmd_data, m_kind, m_ir, m_data);
                    end
                end
            end
            reset = 1'b0;
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_basic_udr();
        test_overrun();
        test_back_to_back();
        test_dual_strobe();
        test_reset_release();
        test_wrap_and_reset_full();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
